pc_fetch_unit: RTL and testbench

Holds the architectural program counter and drives instruction-memory fetch requests with a req/ready handshake. Each cycle it takes the incremented address (PC + 4 from the datapath PC adder) or a taken branch/jump target as the next PC. Outputs PC to the PC adder and instruction memory; flags which returned instructions are valid for decode. Handles stalls, redirects during an outstanding fetch, and misaligned targets.

---
 rtl/pc_fetch_unit_pkg.sv | 25 ++
 rtl/pc_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, instruction
// size, default reset vector and an alignment helper.
package pc_fetch_unit_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  // Every instruction is one 32-bit word, so targets must be word aligned.
  localparam int INSTR_BYTES = 4;
  localparam int ALIGN_BITS  = $clog2(INSTR_BYTES);

  // Reset vector used when the instantiating level does not override it.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // True when the low address bits select the first byte of an instruction.
  function automatic logic is_aligned(input logic [ALIGN_BITS-1:0] low_bits);
    return low_bits == '0;
  endfunction

endpackage : pc_fetch_unit_pkg

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch sequencer. Holds the architectural PC,
// issues fetch requests with a req/ready handshake, tracks redirects that
// arrive while a request is outstanding, and latches a sticky fault on a
// misaligned redirect target. The PC + 4 adder lives outside this block.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] inPCAdder,
  input  logic [XLEN-1:0] branchTarget,
  input  logic            branchTaken,
  input  logic            stall,
  input  logic            imemReady,
  output logic [XLEN-1:0] outPC,
  output logic            imemReq,
  output logic            fetchValid,
  output logic            misaligned
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] saved_q, saved_d;
  logic            pending_q, pending_d;
  logic            valid_q, valid_d;
  logic            fault_q, fault_d;
  logic            bad_target;

  // A redirect whose target does not start an instruction is a fault.
  assign bad_target = branchTaken && !is_aligned(branchTarget[ALIGN_BITS-1:0]);

  // Next-state, next-PC and request logic.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    saved_d   = saved_q;
    pending_d = pending_q;
    valid_d   = 1'b0;
    fault_d   = fault_q;
    imemReq   = 1'b0;

    case (state_q)
      BOOT: begin
        // One idle cycle after reset; redirects are ignored here.
        state_d = FETCH;
      end

      FETCH: begin
        // Reset abandons the outstanding request in the cycle it is sampled.
        imemReq = !reset;
        if (bad_target) begin
          state_d   = FAULT;
          fault_d   = 1'b1;
          pending_d = 1'b0;
        end else begin
          if (imemReady) begin
            if (branchTaken) begin
              // Same-cycle redirect wins; the returning word is wrong-path.
              pc_d      = branchTarget;
              pending_d = 1'b0;
            end else if (pending_q) begin
              // Drop the wrong-path word and jump to the remembered target.
              pc_d      = saved_q;
              pending_d = 1'b0;
            end else begin
              pc_d    = inPCAdder;
              valid_d = 1'b1;
            end
          end else if (branchTaken) begin
            // Request still in flight: remember the youngest target.
            saved_d   = branchTarget;
            pending_d = 1'b1;
          end
          if (stall) begin
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        if (bad_target) begin
          state_d   = FAULT;
          fault_d   = 1'b1;
          pending_d = 1'b0;
        end else begin
          if (branchTaken) begin
            saved_d   = branchTarget;
            pending_d = 1'b1;
          end
          if (!stall) begin
            // Apply any redirect before the first request after the stall.
            state_d = FETCH;
            if (branchTaken) begin
              pc_d      = branchTarget;
              pending_d = 1'b0;
            end else if (pending_q) begin
              pc_d      = saved_q;
              pending_d = 1'b0;
            end
          end
        end
      end

      FAULT: begin
        // Frozen until reset.
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // values from before this edge, independent of statement order.
    if (reset) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      saved_q   <= '0;
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      saved_q   <= saved_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
    end
  end

  assign outPC      = pc_q;
  assign fetchValid = valid_q;
  assign misaligned = fault_q;

endmodule : pc_fetch_unit

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus a randomized
// run, all compared every cycle against a behavioural model of the fetch rules.
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;

  localparam logic [31:0] HIGH_RESET_PC = 32'hFFFF_FFF8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Primary instance, default reset vector.
  logic        reset, branch_taken, stall, imem_ready;
  logic [31:0] branch_target, in_pc_adder, out_pc;
  logic        imem_req, fetch_valid, misaligned;

  assign in_pc_adder = out_pc + 32'd4;

  pc_fetch_unit #(.XLEN(32)) dut (
    .clock(clock), .reset(reset), .inPCAdder(in_pc_adder),
    .branchTarget(branch_target), .branchTaken(branch_taken), .stall(stall),
    .imemReady(imem_ready), .outPC(out_pc), .imemReq(imem_req),
    .fetchValid(fetch_valid), .misaligned(misaligned)
  );

  // Second instance with a reset vector near the top of the address space.
  logic        reset_b, ready_b, branch_taken_b, stall_b;
  logic [31:0] branch_target_b, in_pc_adder_b, out_pc_b;
  logic        imem_req_b, fetch_valid_b, misaligned_b;

  assign in_pc_adder_b = out_pc_b + 32'd4;

  pc_fetch_unit #(.XLEN(32), .RESET_PC(HIGH_RESET_PC)) dut_b (
    .clock(clock), .reset(reset_b), .inPCAdder(in_pc_adder_b),
    .branchTarget(branch_target_b), .branchTaken(branch_taken_b), .stall(stall_b),
    .imemReady(ready_b), .outPC(out_pc_b), .imemReq(imem_req_b),
    .fetchValid(fetch_valid_b), .misaligned(misaligned_b)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model of the primary instance.
  logic [31:0] m_pc, m_saved;
  bit          m_pend, m_valid, m_fault, m_boot, m_hold;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    if (reset) begin
      m_pc = 32'h0; m_saved = 32'h0; m_pend = 0; m_valid = 0;
      m_fault = 0; m_boot = 1; m_hold = 0;
      return;
    end
    m_valid = 0;
    if (m_fault) return;
    if (m_boot) begin
      m_boot = 0;
      return;
    end
    if (branch_taken && branch_target[1:0] != 2'b00) begin
      m_fault = 1; m_pend = 0; m_hold = 0;
      return;
    end
    if (!m_hold) begin
      if (imem_ready) begin
        if (branch_taken)  begin m_pc = branch_target; m_pend = 0; end
        else if (m_pend)   begin m_pc = m_saved;       m_pend = 0; end
        else               begin m_pc = m_pc + 32'd4;  m_valid = 1; end
      end else if (branch_taken) begin
        m_saved = branch_target; m_pend = 1;
      end
      m_hold = stall;
    end else begin
      if (branch_taken) begin m_saved = branch_target; m_pend = 1; end
      if (!stall) begin
        m_hold = 0;
        if (m_pend) begin m_pc = m_saved; m_pend = 0; end
      end
    end
  endtask

  task automatic compare_model();
    check("model_pc",    out_pc,      m_pc);
    check("model_req",   imem_req,    32'(!reset && !m_boot && !m_hold && !m_fault));
    check("model_valid", fetch_valid, 32'(m_valid));
    check("model_mis",   misaligned,  32'(m_fault));
  endtask

  // One clock: update the model, let the edge pass, sample away from it.
  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
    compare_model();
  endtask

  initial begin
    logic [31:0] tgt;
    reset = 1; branch_taken = 0; stall = 0; imem_ready = 1; branch_target = '0;
    reset_b = 1; ready_b = 1; branch_taken_b = 0; stall_b = 0; branch_target_b = '0;

    // Reset state.
    cycle(); cycle();
    check("rst_pc", out_pc, 32'h0);
    check("rst_req", imem_req, 32'h0);
    check("rst_valid", fetch_valid, 32'h0);
    check("rst_mis", misaligned, 32'h0);

    // Boot cycle issues no request, then sequential fetch.
    reset = 0;
    #1;
    check("boot_req", imem_req, 32'h0);
    cycle();
    check("seq_pc0", out_pc, 32'h0);
    check("seq_req0", imem_req, 32'h1);
    check("seq_valid0", fetch_valid, 32'h0);
    cycle();
    check("seq_pc4", out_pc, 32'h4);
    check("seq_valid4", fetch_valid, 32'h1);
    cycle();
    check("seq_pc8", out_pc, 32'h8);

    // Memory not ready for three cycles.
    imem_ready = 0;
    repeat (3) begin
      cycle();
      check("wait_pc", out_pc, 32'h8);
      check("wait_valid", fetch_valid, 32'h0);
    end
    imem_ready = 1;
    cycle();
    check("wait_done_pc", out_pc, 32'hC);
    check("wait_done_valid", fetch_valid, 32'h1);
    cycle();
    check("seq_pc10", out_pc, 32'h10);

    // Redirect while the fetch at 0x10 is outstanding.
    imem_ready = 0; branch_taken = 1; branch_target = 32'h100;
    cycle();
    check("redir_hold_pc", out_pc, 32'h10);
    branch_taken = 0;
    cycle();
    check("redir_hold_pc2", out_pc, 32'h10);
    imem_ready = 1;
    cycle();
    check("redir_pc", out_pc, 32'h100);
    check("redir_drop_valid", fetch_valid, 32'h0);
    cycle();
    check("redir_next_pc", out_pc, 32'h104);
    check("redir_next_valid", fetch_valid, 32'h1);

    // Redirect coincident with ready takes effect immediately.
    branch_taken = 1; branch_target = 32'h20;
    cycle();
    check("direct_redir_pc", out_pc, 32'h20);
    check("direct_redir_valid", fetch_valid, 32'h0);
    branch_taken = 0;

    // Stall at 0x20 with a redirect to 0x40 arriving during the stall.
    stall = 1; imem_ready = 0;
    cycle();
    check("stall_req", imem_req, 32'h0);
    check("stall_pc", out_pc, 32'h20);
    branch_taken = 1; branch_target = 32'h40;
    cycle();
    check("stall_req2", imem_req, 32'h0);
    check("stall_pc2", out_pc, 32'h20);
    branch_taken = 0; stall = 0;
    cycle();
    check("release_pc", out_pc, 32'h40);
    check("release_req", imem_req, 32'h1);
    imem_ready = 1;
    cycle();
    check("release_next_pc", out_pc, 32'h44);

    // Misaligned target faults and freezes the unit until reset.
    branch_taken = 1; branch_target = 32'h102;
    cycle();
    check("fault_mis", misaligned, 32'h1);
    check("fault_req", imem_req, 32'h0);
    check("fault_pc", out_pc, 32'h44);
    repeat (10) begin
      imem_ready = 1'($urandom_range(0, 1));
      stall = 1'($urandom_range(0, 1));
      branch_taken = 1'($urandom_range(0, 1));
      branch_target = $urandom() & 32'hFFFF_FFFC;
      cycle();
      check("fault_frozen_pc", out_pc, 32'h44);
      check("fault_frozen_req", imem_req, 32'h0);
      check("fault_sticky", misaligned, 32'h1);
    end
    reset = 1; branch_taken = 0; stall = 0;
    cycle();
    check("fault_clear_mis", misaligned, 32'h0);
    check("fault_clear_pc", out_pc, 32'h0);
    reset = 0;

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0) || (m_fault && $urandom_range(0, 3) == 0);
      imem_ready = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 4) == 0);
      branch_taken = ($urandom_range(0, 5) == 0);
      tgt = $urandom();
      if ($urandom_range(0, 39) != 0) tgt[1:0] = 2'b00;
      branch_target = tgt;
      cycle();
    end
    reset = 0; branch_taken = 0; stall = 0; imem_ready = 1;

    // High reset vector: sequential fetch wraps through zero.
    ready_b = 1; reset_b = 1;
    cycle();
    reset_b = 0;
    cycle();
    check("wrap_pc0", out_pc_b, 32'hFFFF_FFF8);
    check("wrap_req0", imem_req_b, 32'h1);
    cycle();
    check("wrap_pc1", out_pc_b, 32'hFFFF_FFFC);
    cycle();
    check("wrap_pc2", out_pc_b, 32'h0000_0000);
    check("wrap_valid", fetch_valid_b, 32'h1);

    // Reset during an outstanding request drops the request at once.
    ready_b = 0;
    cycle();
    check("midwait_pc", out_pc_b, 32'h0000_0000);
    check("midwait_req_before", imem_req_b, 32'h1);
    reset_b = 1;
    #1;
    check("midwait_req_drop", imem_req_b, 32'h0);
    cycle();
    check("midwait_rst_pc", out_pc_b, 32'hFFFF_FFF8);
    check("midwait_rst_valid", fetch_valid_b, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pc_fetch_unit
